imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Loads a program into the 32-bit instruction memory from an 8-bit byte stream, then hands the memory address port to the CPU fetch path.
- Sits between the external loader interface, the PC, and the instruction memory write/address ports.
- Holds the CPU stalled until a complete, valid image has been written.
- Replaces hard-coded program initialisation with a runtime load sequence.

Parameters:
- ADDR_W, 10, instruction memory word-address width (matches the PC address).
- DEPTH, 56, number of instruction words; the maximum legal image length.
- TIMEOUT, 1024, maximum clocks allowed between accepted bytes during a load.

Ports:
- clock  in  1  system clock; all logic runs on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load from IDLE, RUN or ERR.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
- pc_adress  in  ADDR_W  CPU fetch address.
- mem_adress  out  ADDR_W  address to instruction memory.
- mem_we  out  1  instruction memory write enable.
- mem_wdata  out  32  instruction memory write data.
- cpu_hold  out  1  stalls the PC and register writes while high.
- load_done  out  1  high while in RUN.
- load_error  out  1  high while in ERR.

Behaviour:
- States: IDLE, HDR0, HDR1, DATA, FLUSH, RUN, ERR. All outputs are registered.
- Reset: state IDLE; byte_ready=0, mem_we=0, mem_wdata=0, mem_adress=0, cpu_hold=1, load_done=0, load_error=0; word counter, byte counter and timeout counter cleared.
  - Reset mid-load aborts immediately. Words already written stay in memory, but the CPU stays held.
- IDLE: waits for start, then goes to HDR0.
- HDR0/HDR1: byte_ready=1. Two bytes form the word count N, big-endian: the HDR0 byte is N[15:8], the HDR1 byte is N[7:0].
  - After the HDR1 transfer: if N==0 or N>DEPTH, go to ERR; otherwise go to DATA.
- DATA: byte_ready=1. Bytes assemble into a word big-endian (first byte = bits 31:24).
  - On the 4th byte of a word: the next cycle drives mem_we=1, mem_wdata=assembled word, mem_adress=word index, starting at 0.
  - The write latency is 1 cycle after the last byte's transfer. mem_we is high for exactly 1 cycle per word.
  - Byte acceptance continues during write cycles; there is no bubble.
- After the transfer of the final byte of word N-1: go to FLUSH. FLUSH performs that word's write cycle with byte_ready=0, then goes to RUN.
- RUN: mem_adress follows pc_adress combinationally through the RUN mux (the only unregistered output path). mem_we=0, byte_ready=0, cpu_hold=0, load_done=1.
- ERR: cpu_hold=1, load_error=1, byte_ready=0, mem_we=0. Leaves only on start (to HDR0) or reset.
- Timeout: in HDR0, HDR1 and DATA, the counter increments each cycle without a transfer and clears on a transfer. When it reaches TIMEOUT-1 without a transfer, the next state is ERR.
- start in HDR0, HDR1, DATA or FLUSH is ignored.
- start in RUN or ERR:
  - Goes to HDR0 and clears the counters.
  - Sets cpu_hold=1 and load_done=0 in the same next cycle.
- Simultaneous start and reset: reset wins.
- Bytes presented while byte_ready=0 are not consumed.
- Word index never exceeds N-1 < DEPTH, so no address wrap can occur.

Decomposition:
- Shared package holds:
  - State enum: IDLE, HDR0, HDR1, DATA, FLUSH, RUN, ERR.
  - IMEM_DEPTH=56 and IMEM_ADDR_W=10, shared with the instruction memory.
  - Header length (2) and bytes-per-word (4) constants.
- One natural sub-module: byte_word_packer. It shifts in 8-bit bytes, flags word_ready on the 4th byte, and clears on start or reset.

Test Plan:
- Load N=2, bytes 00 02 30 06 00 00 00 00 00 00 00 01 with no gaps → mem_we pulses at addr 0 with 0x30060000, then at addr 1 with 0x00000001. cpu_hold falls and load_done rises 1 cycle after the second write.
- Header 00 00 → ERR, load_error=1, no mem_we. Header 00 39 (57 > 56) → ERR.
- byte_valid dropped for 1023 cycles mid-DATA → load continues; dropped for 1024 cycles → ERR, cpu_hold=1.
- In RUN, pc_adress=17 → mem_adress=17 in the same cycle. start pulse → cpu_hold=1 and state HDR0 the next cycle, followed by a successful reload.
- reset asserted during DATA after 5 bytes, then start and a fresh N=1 image → write at addr 0 with the new word, with no residue from the old partial word.
- start asserted during DATA → ignored, and the load completes normally.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, the instruction memory geometry shared
// with the memory itself, and the image framing constants.
package imem_boot_loader_pkg;

  // Instruction memory geometry (shared with the instruction memory).
  localparam int IMEM_DEPTH  = 56;
  localparam int IMEM_ADDR_W = 10;

  // Image framing: big-endian word count header, then big-endian words.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    FLUSH,
    RUN,
    ERR
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Byte-to-word packer for the boot loader.
// Shifts in bytes most-significant first. packed_word is the word that would
// be formed if byte_in is shifted in this cycle; word_ready flags that this
// shift is the last byte of a word.
// Ports:
//   clock       system clock
//   reset       synchronous active-high reset
//   clear       synchronous clear (new load started)
//   shift_en    accept byte_in this cycle
//   byte_in     incoming byte
//   packed_word assembled word including byte_in
//   word_ready  shift_en on the final byte of a word
module imem_boot_loader_byte_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] packed_word,
  output logic        word_ready
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_reg;
  logic [23:0]      shift_reg;

  assign packed_word = {shift_reg, byte_in};
  assign word_ready  = shift_en && (cnt_reg == CNT_W'(BYTES_PER_WORD - 1));

  // The byte counter wraps naturally after the last byte of a word, and the
  // older bytes in shift_reg are fully displaced before the next word forms.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      cnt_reg   <= cnt_reg + 1'b1;
      shift_reg <= packed_word[23:0];
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Receives an image over an 8-bit valid/ready byte stream (2-byte big-endian
// word count, then big-endian 32-bit words), writes it into instruction
// memory from address 0, and then hands the memory address port to the CPU
// fetch path. The CPU is held until a complete, valid image is written.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   start               pulse: begin a new load (from IDLE, RUN or ERR)
//   byte_valid/ready    byte stream handshake, byte_data is the byte
//   pc_adress           CPU fetch address, routed to memory in RUN
//   mem_adress/we/wdata instruction memory address and write port
//   cpu_hold            stalls the CPU while high
//   load_done           high in RUN
//   load_error          high in ERR (bad header or inter-byte timeout)
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] pc_adress,
  output logic [ADDR_W-1:0] mem_adress,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);
  localparam int HDR_W  = 8 * HDR_BYTES;

  state_t              state_reg, state_next;
  logic                byte_ready_reg, byte_ready_next;
  logic                mem_we_reg, mem_we_next;
  logic [31:0]         mem_wdata_reg, mem_wdata_next;
  logic [ADDR_W-1:0]   mem_adress_reg, mem_adress_next;
  logic                cpu_hold_reg, cpu_hold_next;
  logic                load_done_reg, load_done_next;
  logic                load_error_reg, load_error_next;
  logic [ADDR_W-1:0]   word_idx_reg, word_idx_next;
  logic [ADDR_W-1:0]   last_idx_reg, last_idx_next;
  logic [7:0]          n_hi_reg, n_hi_next;
  logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;

  logic                transfer;
  logic                in_load;
  logic                packer_clear;
  logic                packer_shift;
  logic [31:0]         packed_word;
  logic                word_ready;
  logic [HDR_W-1:0]    hdr_n;

  // byte_ready_reg is only ever high in HDR0/HDR1/DATA, so a transfer can
  // only happen in those states.
  assign transfer     = byte_valid && byte_ready_reg;
  assign in_load      = (state_reg == HDR0) || (state_reg == HDR1) || (state_reg == DATA);
  assign packer_clear = start && ((state_reg == IDLE) || (state_reg == RUN) || (state_reg == ERR));
  assign packer_shift = transfer && (state_reg == DATA);

  imem_boot_loader_byte_word_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear       (packer_clear),
    .shift_en    (packer_shift),
    .byte_in     (byte_data),
    .packed_word (packed_word),
    .word_ready  (word_ready)
  );

  assign byte_ready = byte_ready_reg;
  assign mem_we     = mem_we_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign cpu_hold   = cpu_hold_reg;
  assign load_done  = load_done_reg;
  assign load_error = load_error_reg;
  // Fetch path bypasses the register so the CPU sees same-cycle addressing.
  assign mem_adress = (state_reg == RUN) ? pc_adress : mem_adress_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      byte_ready_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
      mem_adress_reg <= '0;
      cpu_hold_reg   <= 1'b1;
      load_done_reg  <= 1'b0;
      load_error_reg <= 1'b0;
      word_idx_reg   <= '0;
      last_idx_reg   <= '0;
      n_hi_reg       <= '0;
      tcnt_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      byte_ready_reg <= byte_ready_next;
      mem_we_reg     <= mem_we_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_adress_reg <= mem_adress_next;
      cpu_hold_reg   <= cpu_hold_next;
      load_done_reg  <= load_done_next;
      load_error_reg <= load_error_next;
      word_idx_reg   <= word_idx_next;
      last_idx_reg   <= last_idx_next;
      n_hi_reg       <= n_hi_next;
      tcnt_reg       <= tcnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    mem_we_next     = 1'b0;
    mem_wdata_next  = mem_wdata_reg;
    mem_adress_next = mem_adress_reg;
    word_idx_next   = word_idx_reg;
    last_idx_next   = last_idx_reg;
    n_hi_next       = n_hi_reg;
    tcnt_next       = tcnt_reg;
    hdr_n           = {n_hi_reg, byte_data};

    case (state_reg)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_next    = HDR0;
          tcnt_next     = '0;
          word_idx_next = '0;
        end
      end
      HDR0: begin
        if (transfer) begin
          n_hi_next  = byte_data;
          state_next = HDR1;
        end
      end
      HDR1: begin
        if (transfer) begin
          if ((hdr_n == '0) || (hdr_n > HDR_W'(DEPTH))) begin
            state_next = ERR;
          end else begin
            state_next    = DATA;
            // Index of the final word, known to fit since N <= DEPTH.
            last_idx_next = ADDR_W'(hdr_n - HDR_W'(1));
          end
        end
      end
      DATA: begin
        if (word_ready) begin
          mem_we_next     = 1'b1;
          mem_wdata_next  = packed_word;
          mem_adress_next = word_idx_reg;
          word_idx_next   = word_idx_reg + 1'b1;
          if (word_idx_reg == last_idx_reg) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        // The last word's write cycle is happening now.
        state_next = RUN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Inter-byte watchdog: the cycle that would make the count reach TIMEOUT
    // without a transfer aborts the load instead.
    if (in_load) begin
      if (transfer) begin
        tcnt_next = '0;
      end else if (tcnt_reg == TCNT_W'(TIMEOUT - 1)) begin
        state_next = ERR;
      end else begin
        tcnt_next = tcnt_reg + 1'b1;
      end
    end

    byte_ready_next = (state_next == HDR0) || (state_next == HDR1) || (state_next == DATA);
    cpu_hold_next   = (state_next != RUN);
    load_done_next  = (state_next == RUN);
    load_error_next = (state_next == ERR);
  end

endmodule
